// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared types and constants for the ADC SPI responder.
//   state_t      - responder frame FSM states
//   CFG_*        - bit positions of the fields in the captured config word
//   DATA_W_DEF / CFG_W_DEF - default sample and config widths
package adc_spi_pkg;

  localparam int unsigned DATA_W_DEF = 12;
  localparam int unsigned CFG_W_DEF  = 6;

  // Config word layout: {sgl, ch[2:0], uni, slp}
  localparam int unsigned CFG_SGL   = 5;
  localparam int unsigned CFG_CH_HI = 4;
  localparam int unsigned CFG_CH_LO = 2;
  localparam int unsigned CFG_UNI   = 1;
  localparam int unsigned CFG_SLP   = 0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer for one asynchronous pin, with
// single-cycle rise/fall pulses derived from the last two sync stages.
//   clk, reset - system clock, asynchronous active-high reset
//   pin        - asynchronous input
//   level      - synchronized level (last stage)
//   rise, fall - one-cycle edge pulses
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], pin};
    end
  end

  assign level = stages[SYNC_STAGES-1];
  assign rise  = stages[SYNC_STAGES-2] & ~stages[SYNC_STAGES-1];
  assign fall  = ~stages[SYNC_STAGES-2] & stages[SYNC_STAGES-1];

endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI responder model of an LTC2308-style ADC.
//   clk, reset              - system clock (>= 8x ADC_SCLK), async active-high reset
//   ADC_CS_N/SCLK/DIN       - frame select, serial clock, config bits from master
//   ADC_DOUT                - sample bits to master, MSB first
//   sample_data             - sample for the current frame, latched at frame start
//   sample_ch               - channel chosen by the previous complete frame
//   cfg_word                - last complete config word {sgl, ch, uni, slp}
//   frame_done/frame_abort  - one-cycle pulses on frame completion / early CS_N rise
//   frame_count             - completed-frame counter (wraps)
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned CFG_W       = CFG_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ADC_CS_N,
  input  logic              ADC_SCLK,
  input  logic              ADC_DIN,
  output logic              ADC_DOUT,
  input  logic [DATA_W-1:0] sample_data,
  output logic [2:0]        sample_ch,
  output logic [CFG_W-1:0]  cfg_word,
  output logic              frame_done,
  output logic              frame_abort,
  output logic [15:0]       frame_count
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CFG_BITS = CNT_W'(CFG_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic cs_level, cs_rise, cs_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic din_level, din_rise, din_fall;
  logic unused_edges;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .reset(reset), .pin(ADC_CS_N),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset(reset), .pin(ADC_SCLK),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .clk(clk), .reset(reset), .pin(ADC_DIN),
    .level(din_level), .rise(din_rise), .fall(din_fall)
  );

  assign unused_edges = ^{cs_level, sclk_level, din_rise, din_fall};

  state_t             state;
  // The MSB goes straight to ADC_DOUT at frame start, so the shifter only
  // holds the remaining DATA_W-1 bits.
  logic [DATA_W-2:0]  tx_sr;
  logic [CFG_W-1:0]   cfg_sr;
  logic [CNT_W-1:0]   bit_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tx_sr       <= '0;
      cfg_sr      <= '0;
      bit_cnt     <= '0;
      ADC_DOUT    <= 1'b0;
      sample_ch   <= '0;
      cfg_word    <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          ADC_DOUT <= 1'b0;
          if (cs_fall) begin
            tx_sr    <= sample_data[DATA_W-2:0];
            bit_cnt  <= '0;
            ADC_DOUT <= sample_data[DATA_W-1];
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // CS_N edges take priority; a coincident SCLK edge is dropped.
          if (cs_rise) begin
            frame_abort <= 1'b1;
            ADC_DOUT    <= 1'b0;
            state       <= IDLE;
          end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt < CFG_BITS) begin
              cfg_sr <= {cfg_sr[CFG_W-2:0], din_level};
            end
            if (bit_cnt == LAST_BIT) begin
              ADC_DOUT <= 1'b0;
              state    <= HOLD;
            end
          end else if (sclk_fall) begin
            ADC_DOUT <= tx_sr[DATA_W-2];
            tx_sr    <= {tx_sr[DATA_W-3:0], 1'b0};
          end
        end
        HOLD: begin
          ADC_DOUT <= 1'b0;
          if (cs_rise) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            cfg_word    <= cfg_sr;
            sample_ch   <= cfg_sr[CFG_CH_HI:CFG_CH_LO];
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: directed bench for adc_spi_responder. A frame-level
// model (expected count/config/channel, pulse tallies per frame) is checked
// every clock by one compare process; literal expectations pin the model.
module tb_adc_spi_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_n, sclk, din, dout;
  logic [11:0] sample_data;
  logic [2:0]  sample_ch;
  logic [5:0]  cfg_word;
  logic        frame_done, frame_abort;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;

  // Frame-level model of the outputs.
  logic [15:0] m_count;
  logic [5:0]  m_cfg;
  logic [2:0]  m_ch;
  bit          m_valid;
  bit          dout_idle;
  int          n_done = 0;
  int          n_abort = 0;

  always #5 clk = ~clk;

  adc_spi_responder #(
    .DATA_W(12),
    .CFG_W(6),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ADC_CS_N(cs_n),
    .ADC_SCLK(sclk),
    .ADC_DIN(din),
    .ADC_DOUT(dout),
    .sample_data(sample_data),
    .sample_ch(sample_ch),
    .cfg_word(cfg_word),
    .frame_done(frame_done),
    .frame_abort(frame_abort),
    .frame_count(frame_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done)  n_done++;
    if (frame_abort) n_abort++;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("frame_count", 32'(frame_count), 32'(m_count));
      check("cfg_word", 32'(cfg_word), 32'(m_cfg));
      check("sample_ch", 32'(sample_ch), 32'(m_ch));
      if (dout_idle) check("dout_idle", 32'(dout), 32'd0);
    end
  end

  // One master frame at SCLK = clk/10. Pins change on clk negedges.
  // collide: CS_N rises together with the last SCLK rise.
  task automatic frame(input logic [11:0] smp, input logic [5:0] cfg, input int rises,
                       input bit collide, input int change_at, input logic [11:0] new_smp,
                       output logic [11:0] rx);
    int  d0, a0;
    bit  full;
    @(negedge clk);
    d0 = n_done;
    a0 = n_abort;
    full = (rises == 12) && !collide;
    rx = '0;
    sample_data = smp;
    dout_idle = 1'b0;
    cs_n = 1'b0;
    #50;
    for (int i = 0; i < rises; i++) begin
      din = (i < 6) ? cfg[5-i] : 1'b0;
      #50;
      if (collide && i == rises - 1) begin
        m_valid = 1'b0;
        cs_n = 1'b1;
      end
      sclk = 1'b1;
      rx = {rx[10:0], dout};
      if (i + 1 == change_at) sample_data = new_smp;
      #50;
      sclk = 1'b0;
    end
    if (!collide) begin
      #50;
      m_valid = 1'b0;
      cs_n = 1'b1;
    end
    #100;
    check("done_pulses", 32'(n_done - d0), full ? 32'd1 : 32'd0);
    check("abort_pulses", 32'(n_abort - a0), full ? 32'd0 : 32'd1);
    if (full) begin
      m_count = m_count + 16'd1;
      m_cfg   = cfg;
      m_ch    = cfg[4:2];
    end
    m_valid = 1'b1;
    dout_idle = 1'b1;
  endtask

  initial begin
    logic [11:0] rx;
    int d0, a0;
    cs_n = 1'b1; sclk = 1'b0; din = 1'b0; sample_data = '0;
    m_count = '0; m_cfg = '0; m_ch = '0; m_valid = 1'b0; dout_idle = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    m_valid = 1'b1;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_count", 32'(frame_count), 32'd0);
    check("rst_cfg", 32'(cfg_word), 32'd0);
    check("rst_ch", 32'(sample_ch), 32'd0);

    // SCLK activity with CS_N high must be ignored.
    d0 = n_done; a0 = n_abort;
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b1; din = 1'b1; #50;
      sclk = 1'b0; din = 1'b0; #50;
    end
    check("idle_done", 32'(n_done - d0), 32'd0);
    check("idle_abort", 32'(n_abort - a0), 32'd0);

    // Single frame.
    frame(12'hA5C, 6'b100100, 12, 1'b0, 0, 12'h000, rx);
    check("single_rx", 32'(rx), 32'hA5C);
    check("single_cfg", 32'(cfg_word), 32'h24);
    check("single_ch", 32'(sample_ch), 32'd1);
    check("single_count", 32'(frame_count), 32'd1);

    // Pipelined channel selection: ch 3, 5, 0.
    frame(12'h3C3, 6'b101100, 12, 1'b0, 0, 12'h000, rx);
    check("pipe1_rx", 32'(rx), 32'h3C3);
    check("pipe1_ch", 32'(sample_ch), 32'd3);
    frame(12'h5F0, 6'b110100, 12, 1'b0, 0, 12'h000, rx);
    check("pipe2_rx", 32'(rx), 32'h5F0);
    check("pipe2_ch", 32'(sample_ch), 32'd5);
    frame(12'h001, 6'b100000, 12, 1'b0, 0, 12'h000, rx);
    check("pipe3_rx", 32'(rx), 32'h001);
    check("pipe3_ch", 32'(sample_ch), 32'd0);
    check("pipe3_count", 32'(frame_count), 32'd4);

    // Abort after 7 SCLK rises, then a good frame.
    frame(12'h5A5, 6'b111111, 7, 1'b0, 0, 12'h000, rx);
    check("abort_rx7", 32'(rx), 32'h2D);
    check("abort_count", 32'(frame_count), 32'd4);
    check("abort_cfg", 32'(cfg_word), 32'h20);
    frame(12'h0F0, 6'b100100, 12, 1'b0, 0, 12'h000, rx);
    check("post_abort_rx", 32'(rx), 32'h0F0);
    check("post_abort_count", 32'(frame_count), 32'd5);

    // sample_data changes after bit 3 must not affect the frame.
    frame(12'h123, 6'b101000, 12, 1'b0, 3, 12'hFFF, rx);
    check("midchg_rx", 32'(rx), 32'h123);
    check("midchg_ch", 32'(sample_ch), 32'd2);

    // CS_N rise coincident with the 12th SCLK rise is an abort.
    frame(12'h456, 6'b110000, 12, 1'b1, 0, 12'h000, rx);
    check("collide_rx", 32'(rx), 32'h456);
    check("collide_count", 32'(frame_count), 32'd6);
    check("collide_cfg", 32'(cfg_word), 32'h28);

    // Counter wrap: preload 0xFFFF, one frame wraps to 0.
    @(negedge clk);
    m_valid = 1'b0;
    force dut.frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count;
    m_count = 16'hFFFF;
    @(negedge clk);
    m_valid = 1'b1;
    frame(12'h7E1, 6'b100100, 12, 1'b0, 0, 12'h000, rx);
    check("wrap_rx", 32'(rx), 32'h7E1);
    check("wrap_count", 32'(frame_count), 32'd0);

    // Reset in the middle of a frame (after the 5th SCLK rise).
    @(negedge clk);
    sample_data = 12'hABC;
    dout_idle = 1'b0;
    cs_n = 1'b0;
    #50;
    for (int i = 0; i < 5; i++) begin
      din = 1'b1; #50;
      sclk = 1'b1; #50;
      if (i < 4) sclk = 1'b0;
    end
    check("pre_reset_dout", 32'(dout), 32'd1);
    m_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_count", 32'(frame_count), 32'd0);
    check("reset_cfg", 32'(cfg_word), 32'd0);
    m_count = '0; m_cfg = '0; m_ch = '0;
    #49;
    sclk = 1'b0; cs_n = 1'b1;
    #50;
    reset = 1'b0;
    @(negedge clk);
    m_valid = 1'b1;
    dout_idle = 1'b1;
    frame(12'h9E7, 6'b111100, 12, 1'b0, 0, 12'h000, rx);
    check("after_reset_rx", 32'(rx), 32'h9E7);
    check("after_reset_count", 32'(frame_count), 32'd1);
    check("after_reset_ch", 32'(sample_ch), 32'd7);

    m_valid = 1'b0;
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
